// File: rtl/alu_pkg.sv
// Shared constants, opcodes and FSM states
// for the execute stage ahead of the register file.
package alu_pkg;
  localparam int ALU_DATA_W    = 13;
  localparam int ALU_REG_AW    = 3;
  localparam int ALU_MUL_STEPS = 13;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WRITE
  } state_e;
endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier.
// Load performs the first partial product, so STEPS-1 further steps finish it.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int W     = ALU_DATA_W,
  parameter int STEPS = ALU_MUL_STEPS
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o,
  output logic           done_o
);
  localparam int CW = 4;

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= b_i[0] ? {{W{1'b0}}, a_i} : '0;
      mcand_q  <= {{W{1'b0}}, a_i} << 1;
      mplier_q <= b_i >> 1;
      cnt_q    <= CW'(1);
    end else if (step_i && !done_o) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign product_o = acc_q;
  assign done_o    = (cnt_q == CW'(STEPS));
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative multiply,
// with registered result, pointer and write strobe for the register file.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W    = ALU_DATA_W,
  parameter int REG_AW    = ALU_REG_AW,
  parameter int MUL_STEPS = ALU_MUL_STEPS
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Opcode,
  input  logic [REG_AW-1:0] Dest,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  output logic [DATA_W-1:0] ALU_Result,
  output logic [REG_AW-1:0] R1,
  output logic              WriteFlag,
  output logic              Overflow,
  output logic              Busy,
  output logic              Done
);
  state_e state_q, state_d;

  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   dest_q;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [REG_AW-1:0]   r1_q;
  logic                ovf_q, ovf_d;
  logic                wf_q, busy_q;
  logic                capture, mul_load, mul_step, mul_done;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   sum, diff;

  alu_shift_add_mul #(
    .W     (DATA_W),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .Clock     (Clock),
    .Reset     (Reset),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (OpA),
    .b_i       (OpB),
    .product_o (product),
    .done_o    (mul_done)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          capture = 1'b1;
          if (Opcode == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = S_MUL;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC:  state_d = S_WRITE;
      S_MUL: begin
        if (mul_done) state_d  = S_WRITE;
        else          mul_step = 1'b1;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Signed overflow: operand sign pattern vs. result sign
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum;
        ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_SHL: begin
        if (int'(b_q[3:0]) >= DATA_W) res_d = '0;
        else                          res_d = a_q << b_q[3:0];
      end
      OP_MUL: begin
        res_d = product[DATA_W-1:0];
        ovf_d = |product[2*DATA_W-1:DATA_W];
      end
      default: res_d = a_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      dest_q <= '0;
      res_q  <= '0;
      r1_q   <= '0;
      ovf_q  <= 1'b0;
      wf_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (capture) begin
        a_q    <= OpA;
        b_q    <= OpB;
        op_q   <= Opcode;
        dest_q <= Dest;
      end
      if (state_d == S_WRITE) begin
        res_q <= res_d;
        r1_q  <= dest_q;
        ovf_q <= ovf_d;
      end
      wf_q   <= (state_d == S_WRITE);
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign ALU_Result = res_q;
  assign R1         = r1_q;
  assign Overflow   = ovf_q;
  assign WriteFlag  = wf_q;
  assign Done       = wf_q;
  assign Busy       = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: cycle-level reference model plus directed
// literal cases and randomized traffic.
module tb_alu_exec_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Opcode = '0;
  logic [2:0]  Dest = '0;
  logic [12:0] OpA = '0;
  logic [12:0] OpB = '0;
  logic [12:0] ALU_Result;
  logic [2:0]  R1;
  logic        WriteFlag, Overflow, Busy, Done;

  alu_exec_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Opcode     (Opcode),
    .Dest       (Dest),
    .OpA        (OpA),
    .OpB        (OpB),
    .ALU_Result (ALU_Result),
    .R1         (R1),
    .WriteFlag  (WriteFlag),
    .Overflow   (Overflow),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit chk_en = 0;

  int wf_e = -10;
  int free_e = 0;
  int p_res = 0, p_r1 = 0;
  bit p_ov = 0;
  int m_res = 0, m_r1 = 0;
  bit m_ov = 0, m_wf = 0, m_busy = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ref_eval(input int op, input int a, input int b,
                          output int res, output bit ov);
    int sa, sb, s, sh, p;
    sa = (a >= 4096) ? a - 8192 : a;
    sb = (b >= 4096) ? b - 8192 : b;
    res = 0;
    ov = 0;
    case (op)
      0: begin s = sa + sb; res = (a + b) % 8192; ov = (s > 4095) || (s < -4096); end
      1: begin s = sa - sb; res = (a - b + 8192) % 8192; ov = (s > 4095) || (s < -4096); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin sh = b % 16; res = (sh >= 13) ? 0 : (a << sh) % 8192; end
      6: begin p = a * b; res = p % 8192; ov = (p >= 8192); end
      default: res = a;
    endcase
  endtask

  always @(posedge Clock) begin
    edge_n++;
    if (Reset) begin
      m_res = 0; m_r1 = 0; m_ov = 0;
      wf_e = -10; free_e = 0;
    end else begin
      if (edge_n == wf_e) begin
        m_res = p_res; m_r1 = p_r1; m_ov = p_ov;
      end
      if (Start && edge_n >= free_e) begin
        ref_eval(int'(Opcode), int'(OpA), int'(OpB), p_res, p_ov);
        p_r1 = int'(Dest);
        wf_e = edge_n + ((Opcode == 3'd6) ? 13 : 1);
        free_e = wf_e + 2;
      end
    end
    m_wf = !Reset && (edge_n == wf_e);
    m_busy = !Reset && (edge_n <= wf_e);
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_WriteFlag", int'(WriteFlag), int'(m_wf));
      check("model_Done", int'(Done), int'(m_wf));
      check("model_Busy", int'(Busy), int'(m_busy));
      check("model_ALU_Result", int'(ALU_Result), m_res);
      check("model_R1", int'(R1), m_r1);
      check("model_Overflow", int'(Overflow), int'(m_ov));
    end
  end

  task automatic do_op(input int op, input int a, input int b, input int d,
                       input int exp_res, input int exp_ov, input int lat);
    int k, n;
    Opcode = 3'(op); OpA = 13'(a); OpB = 13'(b); Dest = 3'(d);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    OpA = 13'($urandom); OpB = 13'($urandom);
    k = edge_n;
    n = 0;
    while (!WriteFlag && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check($sformatf("lit_op%0d_latency", op), edge_n - k, lat);
    check($sformatf("lit_op%0d_result", op), int'(ALU_Result), exp_res);
    check($sformatf("lit_op%0d_ovf", op), int'(Overflow), exp_ov);
    check($sformatf("lit_op%0d_R1", op), int'(R1), d);
    check($sformatf("lit_op%0d_Done", op), int'(Done), 1);
    @(negedge Clock);
    check($sformatf("lit_op%0d_wf_fall", op), int'(WriteFlag), 0);
  endtask

  initial begin
    int k, nwf;
    repeat (3) @(negedge Clock);
    chk_en = 1;
    check("rst_ALU_Result", int'(ALU_Result), 0);
    check("rst_Busy", int'(Busy), 0);
    Reset = 1'b0;
    @(negedge Clock);

    do_op(0, 100, 23, 5, 123, 0, 1);
    do_op(1, 0, 1, 2, 13'h1FFF, 0, 1);
    do_op(0, 13'h0FFF, 1, 3, 13'h1000, 1, 1);
    do_op(6, 45, 37, 4, 1665, 0, 13);
    do_op(6, 100, 100, 7, 1808, 1, 13);
    do_op(5, 1, 12, 1, 4096, 0, 1);
    do_op(5, 1, 13, 6, 0, 0, 1);
    do_op(2, 13'h0F0F, 13'h00FF, 0, 13'h000F, 0, 1);
    do_op(4, 13'h1555, 13'h1FFF, 2, 13'h0AAA, 0, 1);
    do_op(7, 321, 99, 3, 321, 0, 1);

    // Start held every cycle through a multiply
    Opcode = 3'd6; OpA = 13'd45; OpB = 13'd37; Dest = 3'd1;
    Start = 1'b1;
    @(negedge Clock);
    k = edge_n;
    nwf = 0;
    for (int i = 0; i < 16; i++) begin
      nwf += int'(WriteFlag);
      Opcode = 3'($urandom_range(0, 7));
      OpA = 13'($urandom); OpB = 13'($urandom); Dest = 3'($urandom);
      if (i == 14) begin
        Opcode = 3'd0; OpA = 13'd7; OpB = 13'd8; Dest = 3'd2;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    check("hold_wf_count", nwf, 1);
    check("hold_first_idle_wf", int'(WriteFlag), 1);
    check("hold_first_idle_res", int'(ALU_Result), 15);
    check("hold_elapsed", edge_n - k, 16);
    repeat (4) @(negedge Clock);

    // Reset in the middle of a multiply
    Opcode = 3'd6; OpA = 13'd99; OpB = 13'd77; Dest = 3'd5;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_res", int'(ALU_Result), 0);
    check("abort_R1", int'(R1), 0);
    check("abort_busy", int'(Busy), 0);
    nwf = 0;
    for (int i = 0; i < 16; i++) begin
      nwf += int'(WriteFlag);
      @(negedge Clock);
    end
    check("abort_wf_count", nwf, 0);
    do_op(0, 1000, 24, 6, 1024, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      Start = ($urandom_range(0, 2) == 0);
      Opcode = 3'($urandom_range(0, 7));
      Dest = 3'($urandom);
      case ($urandom_range(0, 5))
        0: OpA = 13'h0FFF;
        1: OpA = 13'h1000;
        2: OpA = 13'h1FFF;
        default: OpA = 13'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: OpB = 13'd1;
        1: OpB = 13'd0;
        2: OpB = 13'($urandom_range(0, 15));
        default: OpB = 13'($urandom);
      endcase
      @(negedge Clock);
    end
    Reset = 1'b0;
    Start = 1'b0;
    repeat (20) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
